mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory (the MAR/MDR memory bus) between two requesters: port 0 = CPU control path, port 1 = DMA/program loader.
- Sequences each access through a fixed-latency handshake.
- Sits between the multi-cycle CPU's memory interface and the memory array; the CPU control unit stalls on its port until done is seen.

Parameters:
- AW, 16, address width.
- DW, 32, data width.
- MEM_LAT, 2, memory access cycles (mem_rd/mem_wr held high); legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p0_req  in  1  port 0 request; level, held until p0_done.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  AW  port 0 address.
- p0_wdata  in  DW  port 0 write data.
- p0_gnt  out  1  port 0 owns the bus.
- p0_done  out  1  one-cycle completion pulse.
- p0_rdata  out  DW  port 0 read data, registered.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_done, p1_rdata: same as port 0, for port 1.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_rdata  in  DW  memory read data, valid in the last strobe cycle.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all gnt/done/mem_rd/mem_wr/busy = 0.
  - mem_addr, mem_wdata, p0_rdata, p1_rdata = 0.
  - owner=0; last=1 (so port 0 wins the first tie).
- Reset mid-access drops the strobes immediately (combinationally via async clear); no done is issued.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - On a rising edge with any req high, pick the owner.
  - Latch owner, we, addr, and wdata into registers; load cnt = MEM_LAT-1; go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - gnt[owner]=1; mem_addr/mem_wdata come from the latched values.
  - mem_rd = ~we, mem_wr = we.
  - cnt decrements each cycle. At cnt==0: capture mem_rdata into that port's rdata (reads only; rdata is unchanged on writes), then go to DONE.
- DONE:
  - done[owner]=1 for exactly one cycle; gnt stays high; strobes are low; last = owner.
  - Next state is IDLE.
- Latency: req sampled at edge k -> strobes high in cycles k+1..k+MEM_LAT -> done high in cycle k+MEM_LAT+1.
  - Back-to-back accesses: the next access can start at the edge ending the IDLE cycle, so the minimum period is MEM_LAT+2 cycles.
- Requester rules:
  - Hold req/we/addr/wdata stable until done; inputs are latched at grant, so later changes are ignored.
  - Req still high in the IDLE cycle after DONE counts as a new request.
- Arbitration (default build): fixed priority; port 0 beats port 1 on simultaneous requests.
- A request arriving during ACCESS or DONE waits; it is never dropped.
- Ownership is never pre-empted mid-access.
- Only one gnt may be high at a time. mem_rd and mem_wr are never both high.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - On a simultaneous request in IDLE, the port that was not `last` wins. Ports therefore alternate under continuous contention.
  - A single requester is always granted.
- Not defined: fixed priority, port 0 first; the `last` register is still maintained but ignored.

Test Plan:
- Single read: p0_req=1, we=0, addr=0x0010, mem_rdata=0xDEADBEEF, MEM_LAT=2 -> mem_rd high for 2 cycles with mem_addr=0x0010; p0_done pulses 3 cycles after the req edge; p0_rdata=0xDEADBEEF.
- Single write: p1_req, we=1, addr=0x0004, wdata=0x12345678 -> mem_wr high for 2 cycles with matching addr/data; mem_rd stays 0; p1_done pulses once; p1_rdata unchanged.
- Contention, default build: both req held high for 4 accesses -> all grants go to port 0; p1_gnt never rises.
- Contention with ARB_ROUND_ROBIN_EN: the same stimulus -> grant order 0,1,0,1.
- Late arrival: p1_req asserted during port 0's ACCESS -> port 1 is granted in the access after port 0's DONE; port 0 strobes and rdata are undisturbed.
- Reset mid-access: rst_n=0 during the second strobe cycle -> mem_rd, gnt, and busy drop at once; no done pulse; after release, a pending req restarts a full MEM_LAT access.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing the single-port memory bus between the CPU (port 0) and DMA/loader (port 1).
// Define ARB_ROUND_ROBIN_EN for alternating grants under contention; default is fixed priority to port 0.
module mem_port_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_done,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_done,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t          state;
  state_t          state_nxt;
  logic            owner;
  logic            last;
  logic            lat_we;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic [3:0]      cnt;
  logic            pick;
  logic            start;

  // Winner of the request sampled in IDLE: 0 = CPU port, 1 = DMA port.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    if (p0_req && p1_req) begin
      pick = ~last;
    end else begin
      pick = ~p0_req;
    end
`else
    pick = ~p0_req;
`endif
  end

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last;
  assign unused_last = last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    p0_done   = 1'b0;
    p1_done   = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (p0_req || p1_req) begin
          start     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        p0_gnt = ~owner;
        p1_gnt = owner;
        mem_rd = ~lat_we;
        mem_wr = lat_we;
        if (cnt == 4'd0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        p0_gnt    = ~owner;
        p1_gnt    = owner;
        p0_done   = ~owner;
        p1_done   = owner;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Requester inputs are latched at grant so the bus stays stable for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= 1'b0;
      last      <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= 4'd0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      if (start) begin
        owner     <= pick;
        lat_we    <= pick ? p1_we    : p0_we;
        lat_addr  <= pick ? p1_addr  : p0_addr;
        lat_wdata <= pick ? p1_wdata : p0_wdata;
        cnt       <= CNT_INIT;
      end else if (state == ACCESS) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (!lat_we) begin
          if (owner) begin
            p1_rdata <= mem_rdata;
          end else begin
            p0_rdata <= mem_rdata;
          end
        end
      end
      if (state == DONE) begin
        last <= owner;
      end
    end
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random requesters,
// compared every cycle against a transaction-phase model of the arbiter and a 256-word memory.
module tb_mem_port_arbiter;

  localparam int AW      = 16;
  localparam int DW      = 32;
  localparam int MEM_LAT = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p0_done, p1_gnt, p1_done;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_rd, mem_wr, busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory returns real data only in the last strobe cycle; earlier cycles return a marker.
  logic [DW-1:0] mem_array [256];
  int            strobe_run;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) strobe_run <= 0;
    else        strobe_run <= (mem_rd || mem_wr) ? strobe_run + 1 : 0;
  end

  assign mem_rdata = (mem_rd && strobe_run == MEM_LAT - 1) ? mem_array[mem_addr[7:0]]
                                                            : {16'hBAD0, strobe_run[15:0]};

  // Reference model: phase 0 = idle, 1..MEM_LAT = strobe cycles, MEM_LAT+1 = done cycle.
  int            m_phase;
  bit            m_owner, m_we, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata [2];
  logic [DW-1:0] ref_mem [256];

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_phase    = 0;
    m_owner    = 1'b0;
    m_we       = 1'b0;
    m_last     = 1'b1;
    m_addr     = '0;
    m_wdata    = '0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
  endtask

  task automatic modelEdge();
    if (m_phase == 0) begin
      if (p0_req || p1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        m_owner = (p0_req && p1_req) ? !m_last : !p0_req;
`else
        m_owner = !p0_req;
`endif
        m_we    = m_owner ? p1_we    : p0_we;
        m_addr  = m_owner ? p1_addr  : p0_addr;
        m_wdata = m_owner ? p1_wdata : p0_wdata;
        m_phase = 1;
      end
    end else if (m_phase <= MEM_LAT) begin
      if (m_phase == MEM_LAT) begin
        if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
        else      m_rdata[m_owner] = ref_mem[m_addr[7:0]];
      end
      m_phase++;
    end else begin
      m_last  = m_owner;
      m_phase = 0;
    end
  endtask

  task automatic checkCycle();
    bit strobe;
    strobe = (m_phase >= 1) && (m_phase <= MEM_LAT);
    checkOutput("busy",    busy,    m_phase != 0);
    checkOutput("p0_gnt",  p0_gnt,  (m_phase != 0) && !m_owner);
    checkOutput("p1_gnt",  p1_gnt,  (m_phase != 0) && m_owner);
    checkOutput("p0_done", p0_done, (m_phase == MEM_LAT + 1) && !m_owner);
    checkOutput("p1_done", p1_done, (m_phase == MEM_LAT + 1) && m_owner);
    checkOutput("mem_rd",  mem_rd,  strobe && !m_we);
    checkOutput("mem_wr",  mem_wr,  strobe && m_we);
    if (strobe) checkOutput("mem_addr", mem_addr, m_addr);
    if (strobe && m_we) checkOutput("mem_wdata", mem_wdata, m_wdata);
    checkOutput("p0_rdata", p0_rdata, m_rdata[0]);
    checkOutput("p1_rdata", p1_rdata, m_rdata[1]);
  endtask

  task automatic tick();
    if (mem_wr && strobe_run == MEM_LAT - 1) mem_array[mem_addr[7:0]] = mem_wdata;
    modelEdge();
    @(posedge clk);
    #1;
    checkCycle();
  endtask

  task automatic applyStimulus(input int port, input bit req, input bit we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  task automatic applyRandomRequest(input int port);
    applyStimulus(port, 1'b1, 1'($urandom_range(1)), 16'($urandom), $urandom);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkCycle();
    checkOutput("rst_mem_addr",  mem_addr,  0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitDone(input int port, input int max_cycles, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < max_cycles) begin
      tick();
      cycles++;
      seen = (port == 0) ? p0_done : p1_done;
    end
    checkOutput($sformatf("done_seen_p%0d", port), seen, 1'b1);
  endtask

  task automatic randomRequesters(input bit allow_new);
    bit req_now, done_now;
    for (int p = 0; p < 2; p++) begin
      req_now  = (p == 0) ? p0_req  : p1_req;
      done_now = (p == 0) ? p0_done : p1_done;
      if (req_now && done_now) begin
        if (allow_new && $urandom_range(1) == 1) applyRandomRequest(p);
        else applyStimulus(p, 1'b0, 1'b0, '0, '0);
      end else if (!req_now && allow_new && $urandom_range(2) == 0) begin
        applyRandomRequest(p);
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bit got, who;
    int expected_owner;

    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 256; i++) begin
      mem_array[i] = $urandom;
      ref_mem[i]   = mem_array[i];
    end
    mem_array[8'h10] = 32'hDEADBEEF;
    ref_mem[8'h10]   = 32'hDEADBEEF;

    #1;
    applyReset();
    tick();
    tick();

    $display("[TB] single read");
    applyStimulus(0, 1'b1, 1'b0, 16'h0010, '0);
    waitDone(0, MEM_LAT + 4, n);
    checkOutput("read_latency", n, MEM_LAT + 1);
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("read_rdata", p0_rdata, 32'hDEADBEEF);

    $display("[TB] single write");
    applyStimulus(1, 1'b1, 1'b1, 16'h0004, 32'h12345678);
    waitDone(1, MEM_LAT + 4, n);
    checkOutput("write_latency", n, MEM_LAT + 1);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("write_mem", mem_array[8'h04], 32'h12345678);
    checkOutput("write_p1_rdata", p1_rdata, 0);

    $display("[TB] contention");
    applyReset();
    applyRandomRequest(0);
    applyRandomRequest(1);
    who = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n   = 0;
      got = 1'b0;
      while (!got && n < 4 * (MEM_LAT + 2)) begin
        tick();
        n++;
        if (p0_done || p1_done) begin
          got = 1'b1;
          who = p1_done;
        end
      end
`ifdef ARB_ROUND_ROBIN_EN
      expected_owner = i % 2;
`else
      expected_owner = 0;
`endif
      checkOutput($sformatf("contend_seen_%0d", i), got, 1'b1);
      checkOutput($sformatf("contend_owner_%0d", i), who, expected_owner);
      if (i < 3) applyRandomRequest(int'(who));
      else       applyStimulus(int'(who), 1'b0, 1'b0, '0, '0);
    end
    waitDone(int'(!who), 4 * (MEM_LAT + 2), n);
    applyStimulus(int'(!who), 1'b0, 1'b0, '0, '0);
    tick();

    $display("[TB] late arrival");
    applyStimulus(0, 1'b1, 1'b0, 16'h0A20, '0);
    tick();
    applyStimulus(1, 1'b1, 1'b1, 16'h0B30, 32'hCAFEF00D);
    waitDone(0, MEM_LAT + 4, n);
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    waitDone(1, 2 * MEM_LAT + 6, n);
    checkOutput("late_p1_gap", n, MEM_LAT + 2);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    tick();

    $display("[TB] reset mid-access");
    applyStimulus(0, 1'b1, 1'b0, 16'h0040, '0);
    tick();
    tick();
    applyReset();
    waitDone(0, MEM_LAT + 4, n);
    checkOutput("rst_restart_latency", n, MEM_LAT + 1);
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    tick();

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      tick();
      randomRequesters(1'b1);
    end
    for (int c = 0; c < 40; c++) begin
      tick();
      randomRequesters(1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
